// File: rtl/pc_sequencer_pkg.sv
// Shared processor definitions for the PC sequencer.
// Holds the sequencer state encoding and the fetch increment.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        EXECUTE = 2'd1,
        HALTED  = 2'd2
    } state_t;

    localparam logic [31:0] INSTR_INC = 32'd4;

endpackage

// File: rtl/pc_sequencer_pc.sv
// Program counter register.
// Loads pc_in every cycle; the caller feeds back pc_out to hold.
module pc_sequencer_pc #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_out
);

    // PC register, forced to the reset vector while reset is high
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_out <= RESET_VECTOR;
        end else begin
            pc_out <= pc_in;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute/halt sequencer driving the program counter.
// Selects the next PC and reports retirement and misaligned branches.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        trap,
    input  logic        halt,
    input  logic        resume,
    output logic [31:0] pc_out,
    output logic        retire,
    output logic        misaligned,
    output logic [31:0] instr_count
);

    state_t      state;
    logic [31:0] pc_next;
    logic        accept_fetch;
    logic        accept_exec;
    logic        accept_resume;
    logic        br_misaligned;

    // A fetch is only accepted once the request is actually on the bus
    assign accept_fetch  = (state == FETCH) && imem_req && imem_ready;
    assign accept_exec   = (state == EXECUTE) && exec_done;
    assign accept_resume = (state == HALTED) && resume;
    assign br_misaligned = branch_taken && (branch_target[1:0] != 2'b00);
    assign imem_addr     = pc_out;

    // Next-PC select; holds the current PC unless an update is accepted
    always_comb begin
        pc_next = pc_out;
        if (accept_exec) begin
            if (trap) begin
                pc_next = TRAP_VECTOR;
            end else if (halt) begin
                pc_next = pc_out;
            end else if (br_misaligned) begin
                pc_next = TRAP_VECTOR;
            end else if (branch_taken) begin
                pc_next = branch_target;
            end else begin
                pc_next = pc_out + INSTR_INC;
            end
        end else if (accept_resume) begin
            pc_next = pc_out + INSTR_INC;
        end
    end

    pc_sequencer_pc #(
        .RESET_VECTOR(RESET_VECTOR)
    ) u_pc (
        .clock (clock),
        .reset (reset),
        .pc_in (pc_next),
        .pc_out(pc_out)
    );

    // Sequencer FSM with registered handshake and status outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= FETCH;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            retire      <= 1'b0;
            misaligned  <= 1'b0;
            instr_count <= 32'd0;
        end else begin
            retire     <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                FETCH: begin
                    if (accept_fetch) begin
                        state       <= EXECUTE;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end else begin
                        imem_req    <= 1'b1;
                        instr_valid <= 1'b0;
                    end
                end
                EXECUTE: begin
                    if (exec_done) begin
                        retire      <= 1'b1;
                        instr_count <= instr_count + 32'd1;
                        instr_valid <= 1'b0;
                        if (trap) begin
                            state    <= FETCH;
                            imem_req <= 1'b1;
                        end else if (halt) begin
                            state    <= HALTED;
                            imem_req <= 1'b0;
                        end else begin
                            state      <= FETCH;
                            imem_req   <= 1'b1;
                            misaligned <= br_misaligned;
                        end
                    end
                end
                HALTED: begin
                    instr_valid <= 1'b0;
                    if (resume) begin
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end else begin
                        imem_req <= 1'b0;
                    end
                end
                default: begin
                    state       <= FETCH;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer.
// Table of single-instruction vectors plus hand-written sequences.
module tb_pc_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        instr_valid;
    logic        exec_done = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        trap = 1'b0;
    logic        halt = 1'b0;
    logic        resume = 1'b0;
    logic [31:0] pc_out;
    logic        retire;
    logic        misaligned;
    logic [31:0] instr_count;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_count = 32'd0;

    typedef struct {
        logic        tr;
        logic        hl;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic        mis;
    } vec_t;

    vec_t vt [8];

    pc_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .instr_valid  (instr_valid),
        .exec_done    (exec_done),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .trap         (trap),
        .halt         (halt),
        .resume       (resume),
        .pc_out       (pc_out),
        .retire       (retire),
        .misaligned   (misaligned),
        .instr_count  (instr_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_cnt", instr_count, 32'h0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_mis", {31'd0, misaligned}, 32'd0);
        chk("rst_ival", {31'd0, instr_valid}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        exp_count = 32'd0;
    endtask

    task automatic do_instr(input logic tr, input logic hl,
                            input logic br, input logic [31:0] tgt,
                            input logic [31:0] exp_pc,
                            input logic exp_mis, input logic exp_req);
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        chk("ex_valid", {31'd0, instr_valid}, 32'd1);
        chk("ex_req", {31'd0, imem_req}, 32'd0);
        trap = tr;
        halt = hl;
        branch_taken = br;
        branch_target = tgt;
        exec_done = 1'b1;
        tick();
        exec_done = 1'b0;
        trap = 1'b0;
        halt = 1'b0;
        branch_taken = 1'b0;
        exp_count = exp_count + 32'd1;
        chk("nx_pc", pc_out, exp_pc);
        chk("nx_mis", {31'd0, misaligned}, {31'd0, exp_mis});
        chk("nx_retire", {31'd0, retire}, 32'd1);
        chk("nx_cnt", instr_count, exp_count);
        chk("nx_req", {31'd0, imem_req}, {31'd0, exp_req});
        chk("nx_valid", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        int nret;
        logic [31:0] pc;

        vt[0] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h4,   1'b0};
        vt[1] = '{1'b0, 1'b0, 1'b1, 32'h40,       32'h40,  1'b0};
        vt[2] = '{1'b0, 1'b0, 1'b1, 32'h42,       32'h100, 1'b1};
        vt[3] = '{1'b0, 1'b0, 1'b0, 32'h0,        32'h104, 1'b0};
        vt[4] = '{1'b1, 1'b1, 1'b1, 32'h40,       32'h100, 1'b0};
        vt[5] = '{1'b1, 1'b0, 1'b0, 32'h0,        32'h100, 1'b0};
        vt[6] = '{1'b0, 1'b0, 1'b1, 32'h200,      32'h200, 1'b0};
        vt[7] = '{1'b0, 1'b0, 1'b1, 32'h0000_0003, 32'h100, 1'b1};

        // back-to-back stream with ready and done held high
        do_reset();
        chk("start_pc", pc_out, 32'h0);
        imem_ready = 1'b1;
        exec_done = 1'b1;
        nret = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stream_pc", pc_out, 32'(4 * i));
            chk("stream_ival", {31'd0, instr_valid}, 32'd1);
            if (retire) nret++;
            tick();
            if (retire) nret++;
        end
        imem_ready = 1'b0;
        exec_done = 1'b0;
        chk("stream_retires", 32'(nret), 32'd4);
        chk("stream_cnt", instr_count, 32'd4);
        chk("stream_end_pc", pc_out, 32'h10);

        // fetch stall: no ready for three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_req", {31'd0, imem_req}, 32'd1);
            chk("stall_ival", {31'd0, instr_valid}, 32'd0);
            chk("stall_addr", imem_addr, 32'h10);
        end

        // vector table from a fresh reset
        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_instr(vt[i].tr, vt[i].hl, vt[i].br, vt[i].tgt,
                     vt[i].pc, vt[i].mis, 1'b1);
        end
        tick();
        chk("mis_one_cycle", {31'd0, misaligned}, 32'd0);
        chk("retire_one_cycle", {31'd0, retire}, 32'd0);

        // halt at 0x20, hold, then resume
        do_reset();
        pc = 32'h0;
        for (int i = 0; i < 8; i++) begin
            pc = pc + 32'd4;
            do_instr(1'b0, 1'b0, 1'b0, 32'h0, pc, 1'b0, 1'b1);
        end
        do_instr(1'b0, 1'b1, 1'b1, 32'h80, 32'h20, 1'b0, 1'b0);
        imem_ready = 1'b1;
        exec_done = 1'b1;
        branch_taken = 1'b1;
        branch_target = 32'h80;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halt_req", {31'd0, imem_req}, 32'd0);
            chk("halt_ival", {31'd0, instr_valid}, 32'd0);
            chk("halt_pc", pc_out, 32'h20);
            chk("halt_retire", {31'd0, retire}, 32'd0);
        end
        imem_ready = 1'b0;
        exec_done = 1'b0;
        branch_taken = 1'b0;
        chk("halt_cnt", instr_count, exp_count);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_pc", imem_addr, 32'h24);
        chk("resume_req", {31'd0, imem_req}, 32'd1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_ignored", pc_out, 32'h24);
        do_instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h28, 1'b0, 1'b1);

        // sequential wrap past the top of the address space
        do_instr(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 1'b1);
        do_instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        do_instr(1'b0, 1'b0, 1'b0, 32'h0, 32'h4, 1'b0, 1'b1);

        // reset asserted in the middle of execute
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        chk("pre_rst_ival", {31'd0, instr_valid}, 32'd1);
        exec_done = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_pc", pc_out, 32'h0);
        chk("mid_rst_cnt", instr_count, 32'h0);
        chk("mid_rst_ival", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("mid_rst_retire", {31'd0, retire}, 32'd0);
        chk("mid_rst_pc2", pc_out, 32'h0);
        reset = 1'b0;
        exec_done = 1'b0;
        tick();
        chk("after_rst_retire", {31'd0, retire}, 32'd0);
        chk("after_rst_cnt", instr_count, 32'h0);
        chk("after_rst_req", {31'd0, imem_req}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter TRAP_VECTOR, default 32'h0000_0100, meaning the PC value loaded on a trap or misaligned redirect.
REQ-003 The block SHALL have port clock  input  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port imem_req  output  1  instruction fetch request.
REQ-006 The block SHALL have port imem_addr  output  32  fetch address, equal to pc_out.
REQ-007 The block SHALL have port imem_ready  input  1  instruction memory has returned data for the current request.
REQ-008 The block SHALL have port instr_valid  output  1  fetched instruction is valid for decode/execute.
REQ-009 The block SHALL have port exec_done  input  1  datapath has finished executing the current instruction.
REQ-010 The block SHALL have port branch_taken  input  1  redirect to branch_target on completion.
REQ-011 The block SHALL have port branch_target  input  32  redirect address.
REQ-012 The block SHALL have port trap  input  1  exception on the current instruction.
REQ-013 The block SHALL have port halt  input  1  halt request (ebreak) on the current instruction.
REQ-014 The block SHALL have port resume  input  1  leave HALTED.
REQ-015 The block SHALL have port pc_out  output  32  current program counter.
REQ-016 The block SHALL have port retire  output  1  one-cycle pulse per completed instruction.
REQ-017 The block SHALL have port misaligned  output  1  one-cycle pulse when a taken branch target has bits [1:0] != 0.
REQ-018 The block SHALL have port instr_count  output  32  count of retired instructions.

Function
REQ-019 The FSM SHALL have states FETCH, EXECUTE and HALTED.
REQ-020 In FETCH, imem_req SHALL be 1 and instr_valid 0; the FSM SHALL move to EXECUTE on the first edge where imem_ready=1, and otherwise stay in FETCH for any number of cycles.
REQ-021 In EXECUTE, instr_valid SHALL be 1 and imem_req 0; the FSM SHALL stay in EXECUTE until exec_done=1.
REQ-022 On the edge where exec_done=1 in EXECUTE, the next PC SHALL be selected with priority trap > halt > misaligned branch > branch > sequential.
REQ-023 For trap, the block SHALL set pc_out to TRAP_VECTOR and go to FETCH.
REQ-024 For halt, pc_out SHALL be unchanged and the FSM SHALL go to HALTED.
REQ-025 For branch_taken with branch_target[1:0] != 0, the block SHALL set pc_out to TRAP_VECTOR, pulse misaligned for one cycle, and go to FETCH.
REQ-026 For branch_taken with an aligned target, the block SHALL set pc_out to branch_target and go to FETCH.
REQ-027 Otherwise, the block SHALL set pc_out to pc_out+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0), and go to FETCH.
REQ-028 retire SHALL pulse for exactly one cycle after every exec_done acceptance, including trap, halt and misaligned cases.
REQ-029 instr_count SHALL increment by 1 on each retire and wrap from 32'hFFFF_FFFF to 0.
REQ-030 In HALTED, imem_req and instr_valid SHALL be 0; resume=1 SHALL set pc_out to pc_out+4 and go to FETCH; resume outside HALTED SHALL be ignored.
REQ-031 exec_done, branch_taken, trap and halt SHALL be ignored outside EXECUTE; imem_ready SHALL be ignored outside FETCH.
REQ-032 A fetch-to-execute-to-next-fetch turnaround SHALL take a minimum of 2 cycles per instruction when imem_ready and exec_done are held high.

Reset
REQ-033 Reset SHALL be asynchronous; while reset=1, the FSM SHALL be in FETCH, pc_out SHALL be RESET_VECTOR, instr_count SHALL be 0, and retire and misaligned SHALL be 0.
REQ-034 Reset asserted mid-fetch, mid-execute or in HALTED SHALL abort the operation immediately with no retire pulse.
REQ-035 imem_req SHALL be 1 starting from the first rising clock edge after reset deasserts.

Structure
REQ-036 The state encoding (FETCH, EXECUTE, HALTED) and the instruction-increment constant 4 SHALL live in the shared processor package.
REQ-037 The program counter register SHALL be instantiated as the existing pc sub-module, with pc_in driven by next-PC logic gated to hold its value when no update occurs.

Verification
REQ-038 Bench SHALL drive reset, then imem_ready=1 and exec_done=1 held high, and SHALL check that pc_out reads 0,4,8,12 on alternate cycles, 4 retire pulses occur, and instr_count=4.
REQ-039 Bench SHALL hold imem_ready=0 for 3 cycles in FETCH, and SHALL check that the FSM stays in FETCH with imem_addr stable and no instr_valid.
REQ-040 Bench SHALL drive exec_done with branch_taken=1 and branch_target=32'h40, and SHALL check that the next pc_out is 32'h40; with target 32'h42 it SHALL check pc_out=32'h100 and a misaligned pulse.
REQ-041 Bench SHALL drive exec_done with trap=1, halt=1 and branch_taken=1 simultaneously, and SHALL check that pc_out=32'h100 and the FSM is in FETCH.
REQ-042 Bench SHALL halt at pc=32'h20, hold for 5 cycles, then pulse resume, and SHALL check zero imem_req while halted and a fetch at 32'h24.
REQ-043 Bench SHALL start from pc=32'hFFFF_FFFC with a sequential retire, and SHALL check pc_out=0; it SHALL assert reset in EXECUTE and check pc_out=0, instr_count=0 and no retire pulse.
